// File: rtl/mpc_kob_pkg.sv
// Shared types and defaults for the keep-order buffer (package mpc_types).
// Optional build macro: MPC_KOB_BYPASS_EN (0-cycle fill-to-response bypass for the head slot).
package mpc_types;

  localparam int MPC_KOB_DEPTH_DEFAULT  = 8;
  localparam int MPC_KOB_DATA_W_DEFAULT = 128;
  localparam int MPC_KOB_ID_W_DEFAULT   = $clog2(MPC_KOB_DEPTH_DEFAULT);

  // One out-of-order fill as it travels from a bank: target slot plus payload.
  typedef struct packed {
    logic [MPC_KOB_ID_W_DEFAULT-1:0]   rob_id;
    logic [MPC_KOB_DATA_W_DEFAULT-1:0] rdata;
  } kob_fill_t;

endpackage : mpc_types

// File: rtl/mpc_kob_ptr.sv
// Wrapping pointer with increment enable. The width includes one wrap bit above
// the slot index, so the pointer counts modulo 2*DEPTH.
module mpc_kob_ptr #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  assign ptr_d = inc_i ? ptr_q + W'(1) : ptr_q;
  assign ptr_o = ptr_q;

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : mpc_kob_ptr

// File: rtl/mpc_kob.sv
// Keep-order buffer: slots are allocated in request order, filled out of order
// by banks, and drained strictly in allocation order from the head.
// Optional build macro: MPC_KOB_BYPASS_EN -- a legal fill to the unfilled head
// slot is presented on rsp_* in the same cycle.
module mpc_kob
  import mpc_types::*;
#(
  parameter int DEPTH  = MPC_KOB_DEPTH_DEFAULT,
  parameter int DATA_W = MPC_KOB_DATA_W_DEFAULT,
  parameter int ID_W   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  output logic [ID_W-1:0]   alloc_id_o,
  input  logic              fill_valid_i,
  input  logic [ID_W-1:0]   fill_id_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [ID_W:0]     count_o,
  output logic              err_o
);

  localparam int PW = ID_W + 1;

  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [ID_W-1:0]   head_idx;
  logic [ID_W-1:0]   tail_idx;
  logic              empty;
  logic              full;
  logic              alloc_fire;
  logic              drain;
  logic              fill_legal;
  logic              store_en;
  logic [DEPTH-1:0]  alloc_q;
  logic [DEPTH-1:0]  alloc_d;
  logic [DEPTH-1:0]  filled_q;
  logic [DEPTH-1:0]  filled_d;
  logic              err_q;
  logic              err_d;
  logic [DATA_W-1:0] data_q [DEPTH];

  mpc_kob_ptr #(.W(PW)) u_head_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (drain),
    .ptr_o  (head_q)
  );

  mpc_kob_ptr #(.W(PW)) u_tail_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (alloc_fire),
    .ptr_o  (tail_q)
  );

  assign head_idx = head_q[ID_W-1:0];
  assign tail_idx = tail_q[ID_W-1:0];

  // Equal pointers mean empty; differing only in the wrap bit means full.
  assign empty = (head_q == tail_q);
  assign full  = (head_q[ID_W] != tail_q[ID_W]) && (head_idx == tail_idx);

  // Ready depends only on registered pointers, so a drain cannot free a slot
  // for an allocation in the same cycle.
  assign alloc_ready_o = !full;
  assign alloc_fire    = alloc_valid_i && !full;
  assign alloc_id_o    = tail_idx;
  assign count_o       = tail_q - head_q;
  assign err_o         = err_q;

  // A fill counts only when its slot is waiting for data.
  assign fill_legal = fill_valid_i && alloc_q[fill_id_i] && !filled_q[fill_id_i];

`ifdef MPC_KOB_BYPASS_EN
  logic fill_head;
  logic bypass_hit;

  assign fill_head   = fill_legal && (fill_id_i == head_idx);
  assign bypass_hit  = !empty && !filled_q[head_idx] && fill_head;
  assign rsp_valid_o = (!empty && filled_q[head_idx]) || bypass_hit;
  // A bypassed fill that is consumed immediately never occupies the slot.
  assign store_en    = fill_legal && !(bypass_hit && rsp_ready_i);

  // Head data comes from storage once filled, otherwise straight from the fill port.
  always_comb begin
    rsp_data_o = '0;
    if (!empty && filled_q[head_idx]) begin
      rsp_data_o = data_q[head_idx];
    end else if (bypass_hit) begin
      rsp_data_o = fill_data_i;
    end
  end
`else
  assign rsp_valid_o = !empty && filled_q[head_idx];
  assign rsp_data_o  = rsp_valid_o ? data_q[head_idx] : '0;
  assign store_en    = fill_legal;
`endif

  assign drain = rsp_valid_o && rsp_ready_i;

  // Slot status next-state: drain frees the head, alloc claims the tail, fill marks data present.
  always_comb begin
    alloc_d  = alloc_q;
    filled_d = filled_q;
    err_d    = err_q;
    if (drain) begin
      alloc_d[head_idx]  = 1'b0;
      filled_d[head_idx] = 1'b0;
    end
    if (alloc_fire) begin
      alloc_d[tail_idx]  = 1'b1;
      filled_d[tail_idx] = 1'b0;
    end
    if (store_en) begin
      filled_d[fill_id_i] = 1'b1;
    end
    if (fill_valid_i && !fill_legal) begin
      err_d = 1'b1;
    end
  end

  // Slot status and sticky error flag, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q  <= '0;
      filled_q <= '0;
      err_q    <= 1'b0;
    end else begin
      alloc_q  <= alloc_d;
      filled_q <= filled_d;
      err_q    <= err_d;
    end
  end

  // Response payload storage; contents are qualified by filled_q, so no reset.
  always_ff @(posedge clk_i) begin
    if (store_en) begin
      data_q[fill_id_i] <= fill_data_i;
    end
  end

endmodule : mpc_kob

// File: tb/tb_mpc_kob.sv
// Self-checking bench for mpc_kob: directed scenarios plus a randomized phase,
// all compared each cycle against an in-order queue model of the buffer.
module tb_mpc_kob;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 128;
  localparam int ID_W   = $clog2(DEPTH);

  logic              clk;
  logic              rst_n;
  logic              alloc_v;
  logic              alloc_ready;
  logic [ID_W-1:0]   alloc_id;
  logic              fill_v;
  logic [ID_W-1:0]   fill_id;
  logic [DATA_W-1:0] fill_data;
  logic              rsp_valid;
  logic              rsp_rdy;
  logic [DATA_W-1:0] rsp_data;
  logic [ID_W:0]     count;
  logic              err;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of outstanding slot ids in allocation order.
  int                q[$];
  int                m_tail;
  bit                m_filled [DEPTH];
  logic [DATA_W-1:0] m_data   [DEPTH];
  bit                m_err;

  mpc_kob #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .alloc_valid_i (alloc_v),
    .alloc_ready_o (alloc_ready),
    .alloc_id_o    (alloc_id),
    .fill_valid_i  (fill_v),
    .fill_id_i     (fill_id),
    .fill_data_i   (fill_data),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_rdy),
    .rsp_data_o    (rsp_data),
    .count_o       (count),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit outstanding(input int id);
    foreach (q[i]) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    m_err  = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_filled[i] = 1'b0;
  endtask

  // Expected response for the current inputs and model state.
  task automatic expect_rsp(output bit ev, output logic [DATA_W-1:0] ed, output bit byp);
    bit legal;
    legal = fill_v && outstanding(int'(fill_id)) && !m_filled[fill_id];
    ev  = (q.size() > 0) && m_filled[q[0]];
    ed  = ev ? m_data[q[0]] : '0;
    byp = 1'b0;
`ifdef MPC_KOB_BYPASS_EN
    if (!ev && q.size() > 0 && legal && int'(fill_id) == q[0]) begin
      ev  = 1'b1;
      ed  = fill_data;
      byp = 1'b1;
    end
`endif
  endtask

  task automatic check_outputs(input string tag);
    bit ev;
    bit byp;
    logic [DATA_W-1:0] ed;
    expect_rsp(ev, ed, byp);
    chk({tag, ".alloc_ready"}, DATA_W'(alloc_ready), DATA_W'(q.size() < DEPTH));
    chk({tag, ".alloc_id"},    DATA_W'(alloc_id),    DATA_W'(m_tail % DEPTH));
    chk({tag, ".rsp_valid"},   DATA_W'(rsp_valid),   DATA_W'(ev));
    chk({tag, ".rsp_data"},    rsp_data,             ed);
    chk({tag, ".count"},       DATA_W'(count),       DATA_W'(q.size()));
    chk({tag, ".err"},         DATA_W'(err),         DATA_W'(m_err));
  endtask

  // One clock: check outputs before the edge, then advance the model by the rules.
  task automatic cycle(input string tag);
    bit ev;
    bit byp;
    bit legal;
    bit do_alloc;
    bit do_drain;
    logic [DATA_W-1:0] ed;
    #1;
    check_outputs(tag);
    $display("txn %s: alloc_v=%0d fill_v=%0d fill_id=%0d rsp_rdy=%0d count=%0d rsp_valid=%0d err=%0d",
             tag, alloc_v, fill_v, fill_id, rsp_rdy, count, rsp_valid, err);
    expect_rsp(ev, ed, byp);
    legal    = fill_v && outstanding(int'(fill_id)) && !m_filled[fill_id];
    do_alloc = alloc_v && (q.size() < DEPTH);
    do_drain = ev && rsp_rdy;
    @(posedge clk);
    if (legal && !(byp && do_drain)) begin
      m_filled[fill_id] = 1'b1;
      m_data[fill_id]   = fill_data;
    end
    if (fill_v && !legal) m_err = 1'b1;
    if (do_drain) begin
      m_filled[q[0]] = 1'b0;
      void'(q.pop_front());
    end
    if (do_alloc) begin
      q.push_back(m_tail % DEPTH);
      m_filled[m_tail % DEPTH] = 1'b0;
      m_tail = (m_tail + 1) % (2 * DEPTH);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alloc_v   = 1'b0;
    fill_v    = 1'b0;
    fill_id   = '0;
    fill_data = '0;
    rsp_rdy   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Fill every outstanding unfilled slot in random order, then drain everything.
  task automatic flush_all(input string tag);
    int pend[$];
    int k;
    idle_inputs();
    foreach (q[i]) if (!m_filled[q[i]]) pend.push_back(q[i]);
    while (pend.size() > 0) begin
      k = $urandom_range(pend.size() - 1);
      fill_v    = 1'b1;
      fill_id   = ID_W'(pend[k]);
      fill_data = rnd_data();
      pend.delete(k);
      cycle({tag, ".fill"});
    end
    fill_v  = 1'b0;
    rsp_rdy = 1'b1;
    for (int n = 0; n < 2 * DEPTH && q.size() > 0; n++) cycle({tag, ".drain"});
    rsp_rdy = 1'b0;
    cycle({tag, ".empty"});
  endtask

  initial begin
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [DATA_W-1:0] c_data;
    int pend[$];

    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // 8 allocations with no drain, then a 9th that must stall.
    alloc_v = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle("alloc8");
    alloc_v = 1'b0;
    chk("full.count", DATA_W'(count), DATA_W'(DEPTH));

    // Full with head filled: drain happens, alloc stalls, then alloc gets id 0.
    fill_v = 1'b1; fill_id = '0; fill_data = rnd_data();
    cycle("full.fill_head");
    fill_v = 1'b0; alloc_v = 1'b1; rsp_rdy = 1'b1;
    cycle("full.drain_stall");
    rsp_rdy = 1'b0;
    cycle("full.wrap_grant");
    alloc_v = 1'b0;
    cycle("full.after");

    // Out-of-order fills 2,0,1 must come out as B,C,A.
    do_reset();
    alloc_v = 1'b1;
    for (int i = 0; i < 3; i++) cycle("ooo.alloc");
    alloc_v = 1'b0;
    a_data = rnd_data(); b_data = rnd_data(); c_data = rnd_data();
    fill_v = 1'b1;
    fill_id = 2'd2; fill_data = a_data; cycle("ooo.fill2");
    fill_id = 2'd0; fill_data = b_data; cycle("ooo.fill0");
    fill_id = 2'd1; fill_data = c_data; cycle("ooo.fill1");
    fill_v = 1'b0;
    chk("ooo.first", rsp_data, b_data);
    rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) cycle("ooo.drain");
    rsp_rdy = 1'b0;

    // Fill to an unallocated slot raises a sticky error.
    fill_v = 1'b1; fill_id = 3'd5; fill_data = rnd_data();
    cycle("err.fill5");
    fill_v = 1'b0;
    for (int i = 0; i < 3; i++) cycle("err.sticky");

    // Head unfilled, fill head with 0xDEAD while the channel is ready.
    alloc_v = 1'b1;
    for (int i = 0; i < 2; i++) cycle("byp.alloc");
    alloc_v = 1'b0;
    fill_v = 1'b1; fill_id = ID_W'(q[0]); fill_data = DATA_W'(16'hDEAD); rsp_rdy = 1'b1;
    cycle("byp.fill_head");
    fill_v = 1'b0;
    cycle("byp.next");
    flush_all("byp");

    // Randomized phase: mixed alloc, fill (occasionally illegal) and drain.
    for (int n = 0; n < 400; n++) begin
      alloc_v = ($urandom_range(99) < 60);
      rsp_rdy = ($urandom_range(99) < 50);
      pend.delete();
      foreach (q[i]) if (!m_filled[q[i]]) pend.push_back(q[i]);
      fill_v    = 1'b0;
      fill_data = rnd_data();
      if ($urandom_range(99) < 5) begin
        fill_v  = 1'b1;
        fill_id = ID_W'($urandom_range(DEPTH - 1));
      end else if (pend.size() > 0 && $urandom_range(99) < 70) begin
        fill_v  = 1'b1;
        fill_id = ID_W'(pend[$urandom_range(pend.size() - 1)]);
      end
      cycle("rand");
    end
    flush_all("rand");

    // Reset mid-operation with 4 slots outstanding, then a late fill of id 1.
    do_reset();
    alloc_v = 1'b1;
    for (int i = 0; i < 4; i++) cycle("mid.alloc");
    alloc_v = 1'b0;
    fill_v = 1'b1; fill_id = '0; fill_data = rnd_data();
    cycle("mid.fill0");
    fill_v = 1'b0;
    chk("mid.valid_before", DATA_W'(rsp_valid), DATA_W'(1));
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("mid.async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    fill_v = 1'b1; fill_id = 3'd1; fill_data = rnd_data();
    cycle("mid.late_fill");
    fill_v = 1'b0;
    cycle("mid.err");
    chk("mid.err_set", DATA_W'(err), DATA_W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mpc_kob

// File: doc/mpc_kob.md
MPC_KOB -- requirements
Module: mpc_kob

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of keep-order slots; power of two, 2..64.
REQ-002 SHALL have parameter DATA_W, default 128: response data width.
REQ-003 SHALL have parameter ID_W, default $clog2(DEPTH): slot id width.
REQ-004 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port alloc_valid_i, input, 1: the channel issues a request and needs a slot.
REQ-007 SHALL have port alloc_ready_o, output, 1: a slot is free.
REQ-008 SHALL have port alloc_id_o, output, ID_W: slot id granted on alloc handshake (tail pointer).
REQ-009 SHALL have port fill_valid_i, input, 1: an out-of-order response arrives from a bank.
REQ-010 SHALL have port fill_id_i, input, ID_W: slot targeted by the fill.
REQ-011 SHALL have port fill_data_i, input, DATA_W: response data.
REQ-012 SHALL have port rsp_valid_o, output, 1: in-order head response available.
REQ-013 SHALL have port rsp_ready_i, input, 1: the channel accepts the head response.
REQ-014 SHALL have port rsp_data_o, output, DATA_W: head response data.
REQ-015 SHALL have port count_o, output, ID_W+1: number of allocated slots.
REQ-016 SHALL have port err_o, output, 1: sticky protocol-error flag.

Function
REQ-017 SHALL keep head and tail pointers of ID_W+1 bits; the MSB is a wrap bit; empty when the pointers are equal; full when only the MSBs differ.
REQ-018 SHALL drive alloc_ready_o = !full, with no combinational path from rsp_ready_i; an allocation in the same cycle as a drain while full SHALL be stalled.
REQ-019 SHALL, on alloc_valid_i & alloc_ready_o, mark slot tail as allocated-unfilled and increment tail modulo 2*DEPTH.
REQ-020 SHALL always accept a fill (no ready); a fill to an allocated-unfilled slot SHALL store the data and set the slot's filled bit on the next edge.
REQ-021 SHALL ignore a fill to an unallocated or already-filled slot, and SHALL set err_o on the next edge.
REQ-022 SHALL drive rsp_valid_o = !empty & filled[head]; SHALL drive rsp_data_o = data[head] when valid and 0 otherwise.
REQ-023 SHALL, on rsp_valid_o & rsp_ready_i, clear the allocated and filled bits of head and increment head; if rsp_ready_i is low, rsp_data_o SHALL stay stable.
REQ-024 SHALL allow alloc, fill and drain in the same cycle on distinct slots; count_o SHALL change by (alloc - drain).
REQ-025 SHALL, without bypass, have fill-to-rsp_valid_o latency of 1 cycle for the head slot.

Reset
REQ-026 SHALL, while rst_ni is low, clear head, tail, allocated/filled bits and err_o asynchronously; data storage SHALL NOT be reset.
REQ-027 SHALL drive the following reset outputs: alloc_ready_o=1, alloc_id_o=0, rsp_valid_o=0, rsp_data_o=0, count_o=0, err_o=0.
REQ-028 SHALL discard all outstanding slots if reset is asserted mid-operation; fills arriving after reset SHALL raise err_o.

Configuration
REQ-029 SHALL honour macro MPC_KOB_BYPASS_EN: when defined, a legal fill to the head slot while the head is unfilled SHALL drive rsp_valid_o=1 and rsp_data_o=fill_data_i in the same cycle (0-cycle latency).
REQ-030 SHALL, when a bypass fill is drained the same cycle, not store that data and leave the slot freed.
REQ-031 SHALL, when MPC_KOB_BYPASS_EN is undefined, have no combinational path from the fill_* ports to the rsp_* ports (REQ-025 applies).

Structure
REQ-032 SHALL add to package mpc_types: typedef kob_fill_t {rob_id, rdata}, and constant MPC_KOB_DEPTH_DEFAULT=8.
REQ-033 SHALL instantiate sub-module mpc_kob_ptr (ID_W+1-bit wrapping pointer with increment enable) twice, once for head and once for tail.

Verification
REQ-034 SHALL cover: 8 allocs, no drain -> ids 0..7, count_o=8, alloc_ready_o=0; 9th alloc stalls.
REQ-035 SHALL cover: alloc ids 0,1,2; fill order 2,0,1 with data A,B,C -> rsp order B,C,A; rsp_valid_o rises only after id0 is filled.
REQ-036 SHALL cover: fill id 5 while unallocated -> err_o=1 next cycle and stays 1; storage unchanged.
REQ-037 SHALL cover: full, with head filled, alloc_valid_i=1 and rsp_ready_i=1 -> drain occurs, alloc stalls that cycle, alloc granted next cycle with id 0 after wrap.
REQ-038 SHALL cover, with MPC_KOB_BYPASS_EN: head unfilled, fill head with 0xDEAD and rsp_ready_i=1 -> rsp_valid_o=1 and data 0xDEAD in the same cycle; without the macro -> valid one cycle later.
REQ-039 SHALL cover: rst_ni low mid-operation with 4 slots outstanding -> count_o=0 and rsp_valid_o=0 immediately; a subsequent fill of id 1 -> err_o=1.
